// File: rtl/mbe_pkg.sv
// Shared definitions for the radix-8 MBE partial-product accumulator:
// operand/product widths, the accumulator FSM state type and the
// partial-product word type.
package mbe_pkg;

  localparam int NUM_PP      = 9;
  localparam int IN_NBIT     = 24;
  localparam int PP_NBIT     = 27;
  localparam int PROD_NBIT   = 2 * IN_NBIT;
  localparam int RADIX_SHIFT = 3;
  localparam int IDX_NBIT    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } acc_state_t;

  typedef logic [PP_NBIT-1:0] pp_t;

endpackage

// File: rtl/mbe_term_align.sv
// Turns one captured partial product into its aligned product-width term:
// sign-extend, add the one's-complement correction bit, then shift left by
// RADIX_SHIFT bits per Booth digit position. Purely combinational.
module mbe_term_align
  import mbe_pkg::*;
(
  input  pp_t                   pp_i,
  input  logic                  sign_i,
  input  logic [IDX_NBIT-1:0]   index_i,
  output logic [PROD_NBIT-1:0]  term_o
);

  logic [PROD_NBIT-1:0] ext;
  logic [5:0]           shamt;

  // Two's-complement value of the partial product, modulo 2^PROD_NBIT.
  assign ext   = {{(PROD_NBIT-PP_NBIT){pp_i[PP_NBIT-1]}}, pp_i} + PROD_NBIT'(sign_i);
  // Each Booth digit is worth a factor of 8, i.e. three bit positions.
  assign shamt = 6'(RADIX_SHIFT) * {2'b00, index_i};
  assign term_o = ext << shamt;

endmodule

// File: rtl/mbe_pp_accumulator.sv
// Consumer end of the radix-8 MBE partial-product interface. Captures one
// set of partial products on the input handshake, sums one aligned term per
// cycle into the mantissa product, then presents it on a valid/ready output.
// Optional build macro PP_ACC_EARLY_EXIT_EN: stop accumulating as soon as
// every remaining captured term is zero (product value is unchanged).
module mbe_pp_accumulator
  import mbe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  pp_t                   pp0,
  input  pp_t                   pp1,
  input  pp_t                   pp2,
  input  pp_t                   pp3,
  input  pp_t                   pp4,
  input  pp_t                   pp5,
  input  pp_t                   pp6,
  input  pp_t                   pp7,
  input  logic [IN_NBIT-1:0]    pp8,
  input  logic [NUM_PP-2:0]     sign_bits,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PROD_NBIT-1:0]  product
);

  acc_state_t            state_q, state_d;
  logic [PROD_NBIT-1:0]  acc_q, acc_d;
  logic [IDX_NBIT-1:0]   index_q, index_d;
  // Index NUM_PP-1 holds pp8 zero-extended, so one mux serves all terms.
  pp_t                   cap_q [NUM_PP];
  logic [NUM_PP-1:0]     sign_q;

  logic                  accept;
  logic                  last_term;
  pp_t                   sel_pp;
  logic                  sel_sign;
  logic [PROD_NBIT-1:0]  term;

  assign accept = (state_q == IDLE) && in_valid;

  // Select the captured term addressed by the running index.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sel_pp   = '0;
    sel_sign = 1'b0;
    if (index_q < IDX_NBIT'(NUM_PP)) begin
      sel_pp   = cap_q[index_q];
      sel_sign = sign_q[index_q];
    end
  end

  mbe_term_align u_term_align (
    .pp_i    (sel_pp),
    .sign_i  (sel_sign),
    .index_i (index_q),
    .term_o  (term)
  );

`ifdef PP_ACC_EARLY_EXIT_EN
  logic [NUM_PP-1:0] nz_term;
  logic              rest_zero;

  // Flag captured terms that contribute a nonzero value.
  always_comb begin
    for (int i = 0; i < NUM_PP; i++) begin
      nz_term[i] = (|cap_q[i]) | sign_q[i];
    end
  end

  // True when every term above the current index is zero.
  assign rest_zero = ((nz_term >> index_q) >> 1) == '0;
  assign last_term = (index_q == IDX_NBIT'(NUM_PP-1)) || rest_zero;
`else
  assign last_term = (index_q == IDX_NBIT'(NUM_PP-1));
`endif

  // FSM next state, accumulator and index update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    index_d = index_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = '0;
          index_d = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + term;
        if (last_term) begin
          state_d = DONE;
        end else begin
          index_d = index_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers plus input capture on the input handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state is assigned with <= only, so every register
      // samples pre-edge values regardless of statement order.
      state_q <= IDLE;
      acc_q   <= '0;
      index_q <= '0;
      sign_q  <= '0;
      // NOTE: the capture array is small and must read as zero after reset,
      // so it is cleared here rather than left as an unreset memory.
      for (int i = 0; i < NUM_PP; i++) begin
        cap_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      index_q <= index_d;
      if (accept) begin
        cap_q[0] <= pp0;
        cap_q[1] <= pp1;
        cap_q[2] <= pp2;
        cap_q[3] <= pp3;
        cap_q[4] <= pp4;
        cap_q[5] <= pp5;
        cap_q[6] <= pp6;
        cap_q[7] <= pp7;
        cap_q[8] <= pp_t'(pp8);
        sign_q   <= {1'b0, sign_bits};
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = out_valid ? acc_q : '0;

endmodule

// File: tb/tb_mbe_pp_accumulator.sv
// Directed self-checking bench for mbe_pp_accumulator. Expected products are
// hand-computed; expected latency follows the PP_ACC_EARLY_EXIT_EN build.
module tb_mbe_pp_accumulator;
  import mbe_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0][26:0]      pp_v;
  logic [23:0]           pp8_v;
  logic [7:0]            sign_v;
  logic                  out_valid;
  logic                  out_ready;
  logic [47:0]           product;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mbe_pp_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp0       (pp_v[0]),
    .pp1       (pp_v[1]),
    .pp2       (pp_v[2]),
    .pp3       (pp_v[3]),
    .pp4       (pp_v[4]),
    .pp5       (pp_v[5]),
    .pp6       (pp_v[6]),
    .pp7       (pp_v[7]),
    .pp8       (pp8_v),
    .sign_bits (sign_v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycles from handshake to out_valid; h = highest nonzero term index.
  function automatic int exp_lat(input int h);
`ifdef PP_ACC_EARLY_EXIT_EN
    return 2 + h;
`else
    return 10 + 0 * h;
`endif
  endfunction

  task automatic drive_set(input logic [7:0][26:0] pv, input logic [23:0] p8, input logic [7:0] sb);
    pp_v   = pv;
    pp8_v  = p8;
    sign_v = sb;
  endtask

  // After the handshake, garbage on the inputs must not affect the result.
  task automatic scramble();
    pp_v   = '1;
    pp8_v  = '1;
    sign_v = '1;
  endtask

  // Wait for out_valid; lat starts at 1 in the cycle after the handshake.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_set(input string tag, input logic [7:0][26:0] pv, input logic [23:0] p8,
                         input logic [7:0] sb, input logic [47:0] exp_prod, input int h);
    int lat;
    @(posedge clk); #1;
    drive_set(pv, p8, sb);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check({tag, "_rdy"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    check({tag, "_busy"}, in_ready, 0);
    wait_out(lat);
    check({tag, "_lat"}, lat, exp_lat(h));
    check({tag, "_prod"}, product, exp_prod);
    @(posedge clk); #1;
    check({tag, "_drain"}, out_valid, 0);
  endtask

  initial begin
    logic [7:0][26:0] pv;
    int lat;
    int seen_valid;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    pp_v = '0; pp8_v = '0; sign_v = '0;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
    #10 rst = 1'b0;

    // X=Y=1
    pv = '0; pv[0] = 27'h0000001;
    run_set("one", pv, 24'h0, 8'h00, 48'h1, 0);

    // -1 + 8
    pv = '0; pv[0] = 27'h7FFFFFE; pv[1] = 27'h0000001;
    run_set("neg_pos", pv, 24'h0, 8'h01, 48'h7, 1);

    // X=Y=0xFFFFFF: digit0=-1, digits1..7=0, pp8=X
    pv = '0; pv[0] = 27'h7000000;
    run_set("max", pv, 24'hFFFFFF, 8'h01, 48'hFFFFFE000001, 8);

    // every term = 1: sum 8^i (i=0..7) + 2^24
    for (int i = 0; i < 8; i++) pv[i] = 27'h1;
    run_set("all_ones", pv, 24'h1, 8'h00, 48'h1249249, 8);

    // -2^21 + 2^24, borrow wraps past bit 47
    pv = '0; pv[7] = 27'h7FFFFFE;
    run_set("neg_top", pv, 24'h1, 8'h80, 48'hE00000, 8);

    // -3*2^9 + 2^12
    pv = '0; pv[3] = 27'h7FFFFFC; pv[4] = 27'h1;
    run_set("mid", pv, 24'h0, 8'h08, 48'hA00, 4);

    pv = '0; pv[0] = 27'h0000005;
    run_set("five", pv, 24'h0, 8'h00, 48'h5, 0);

    pv = '0;
    run_set("zero", pv, 24'h0, 8'h00, 48'h0, 0);

    // Backpressure: hold out_ready low for 5 cycles after out_valid.
    @(posedge clk); #1;
    pv = '0; pv[0] = 27'h1;
    drive_set(pv, 24'h0, 8'h00);
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    wait_out(lat);
    check("bp_lat", lat, exp_lat(0));
    pv = '0; pv[1] = 27'h2;
    drive_set(pv, 24'h0, 8'h00);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_prod", product, 48'h1);
      check("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_valid", out_valid, 0);
    check("bp_rel_ready", in_ready, 1);
    @(posedge clk); #1;
    check("bp_second_acc", in_ready, 0);
    in_valid = 1'b0;
    scramble();
    wait_out(lat);
    check("bp_second_lat", lat, exp_lat(1));
    check("bp_second_prod", product, 48'h10);
    @(posedge clk); #1;

    // Reset during the 4th ACC cycle.
    pv = '0;
    for (int i = 0; i < 8; i++) pv[i] = 27'h1;
    drive_set(pv, 24'h1, 8'h00);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_prod", product, 0);
    check("mid_rst_ready", in_ready, 1);
    #1 rst = 1'b0;
    seen_valid = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1;
    end
    check("mid_rst_no_valid", seen_valid, 0);

    pv = '0; pv[0] = 27'h0000003;
    run_set("after_rst", pv, 24'h0, 8'h00, 48'h3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
